// File: rtl/core_pkg.sv
// core_pkg: shared fetch FSM states, fault cause codes and reset PC default
package core_pkg;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_BUS      = 2'd1;
    localparam logic [1:0] FC_MISALIGN = 2'd2;

    localparam logic [31:0] CORE_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter flop with load enable and wrapping pc+4 adder
module pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_d,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4
);

    logic [XLEN-1:0] r_pc;

    // PC changes only when decode consumes the current instruction
    always_ff @(posedge clk or posedge rst)
        if (rst) r_pc <= RESET_PC;
        else if (i_load) r_pc <= i_d;

    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc + XLEN'(4);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-outstanding instruction fetch with PC ownership and decode handshake
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = CORE_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_err,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] next_pc,
    output logic            fetch_fault,
    output logic [1:0]      fault_cause,
    output logic [31:0]     fetch_count
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_instr;
    logic [1:0]      r_cause;
    logic [31:0]     r_count;
    logic            w_consume;

    assign w_consume = (r_state == HOLD) && instr_ready;

    pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_consume),
        .i_d        (next_pc),
        .o_pc       (pc),
        .o_pc_plus4 (pc_plus4)
    );

    // Fetch sequencing, instruction capture, fault latching and consume counting
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= BOOT;
            r_instr <= '0;
            r_cause <= FC_NONE;
            r_count <= '0;
        end else begin
            case (r_state)
                BOOT: r_state <= REQ;
                REQ:  if (imem_gnt) r_state <= WAIT;
                WAIT: if (imem_rvalid) begin
                    if (imem_err) begin
                        r_cause <= FC_BUS;
                        r_state <= FAULT;
                    end else begin
                        r_instr <= imem_rdata;
                        r_state <= HOLD;
                    end
                end
                HOLD: if (instr_ready) begin
                    r_count <= r_count + 32'd1;
                    if (next_pc[1:0] != 2'b00) begin
                        r_cause <= FC_MISALIGN;
                        r_state <= FAULT;
                    end else begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= r_state;
            endcase
        end

    assign imem_req    = (r_state == REQ);
    assign imem_addr   = pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == HOLD);
    assign fetch_fault = (r_state == FAULT);
    assign fault_cause = r_cause;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        pend;
    logic        rv_force;
    logic        use_plus4;
    logic [31:0] np_manual;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause),
        .fetch_count (fetch_count)
    );

    // Zero-wait memory: response one cycle after each granted request
    always_ff @(posedge clk or posedge rst)
        if (rst) pend <= 1'b0;
        else pend <= imem_req & imem_gnt;

    assign imem_rvalid = pend | rv_force;
    assign next_pc     = use_plus4 ? pc_plus4 : np_manual;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b1; imem_rdata = 32'h0000_0013; imem_err = 1'b0;
        instr_ready = 1'b1; rv_force = 1'b0; use_plus4 = 1'b1; np_manual = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_fault", {29'b0, fetch_fault, fault_cause}, 32'd0);
        rst = 1'b0;
        #1;
        chk("boot_req", {31'b0, imem_req}, 32'd0);
        // Sequential fetch stream 0x0, 0x4, 0x8
        step(); chk("s0_req", {31'b0, imem_req}, 32'd1); chk("s0_addr", imem_addr, 32'h0);
        step(); chk("s0_wait_req", {31'b0, imem_req}, 32'd0); chk("s0_wait_valid", {31'b0, instr_valid}, 32'd0);
        step(); chk("s0_valid", {31'b0, instr_valid}, 32'd1); chk("s0_instr", instr, 32'h13);
        step(); chk("s1_addr", imem_addr, 32'h4); chk("s1_req", {31'b0, imem_req}, 32'd1); chk("s1_count", fetch_count, 32'd1);
        chk("s1_valid", {31'b0, instr_valid}, 32'd0);
        step(); step(); chk("s1_valid_hold", {31'b0, instr_valid}, 32'd1);
        step(); chk("s2_addr", imem_addr, 32'h8); chk("s2_count", fetch_count, 32'd2);
        step(); step(); chk("s2_hold_pc", pc, 32'h8);
        step(); chk("s3_addr", imem_addr, 32'hC); chk("s3_count", fetch_count, 32'd3);
        step(); step(); step(); chk("s4_addr", imem_addr, 32'h10);
        step(); step(); chk("br_hold_pc", pc, 32'h10); chk("br_hold_valid", {31'b0, instr_valid}, 32'd1);
        // Branch redirect to 0x40
        use_plus4 = 1'b0; np_manual = 32'h40;
        step(); chk("br_addr", imem_addr, 32'h40); chk("br_plus4", pc_plus4, 32'h44); chk("br_count", fetch_count, 32'd5);
        // Backpressure at 0x40 with a distinct instruction word
        use_plus4 = 1'b1; instr_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        step(); step(); chk("bp_valid", {31'b0, instr_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_instr", instr, 32'hDEAD_BEEF);
            chk("bp_pc", pc, 32'h40);
            chk("bp_req", {31'b0, imem_req}, 32'd0);
            chk("bp_count", fetch_count, 32'd5);
        end
        instr_ready = 1'b1;
        step(); chk("bp_adv_addr", imem_addr, 32'h44); chk("bp_adv_count", fetch_count, 32'd6);
        step(); chk("bp_single_count", fetch_count, 32'd6); chk("bp_single_pc", pc, 32'h44);
        step(); chk("hold44_pc", pc, 32'h44);
        // Redirect to the top of the address space: pc+4 wraps to 0
        use_plus4 = 1'b0; np_manual = 32'hFFFF_FFFC;
        step(); chk("wrap_addr", imem_addr, 32'hFFFF_FFFC); chk("wrap_plus4", pc_plus4, 32'h0); chk("wrap_count", fetch_count, 32'd7);
        step(); step(); chk("wrap_hold", {31'b0, instr_valid}, 32'd1);
        // Misaligned next_pc
        np_manual = 32'h22;
        step(); chk("mis_cause", {30'b0, fault_cause}, 32'd2); chk("mis_pc", pc, 32'h22);
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1); chk("mis_valid", {31'b0, instr_valid}, 32'd0);
        chk("mis_count", fetch_count, 32'd8);
        for (int i = 0; i < 3; i++) begin step(); chk("mis_noreq", {31'b0, imem_req}, 32'd0); end
        // Reset in the middle of WAIT, stale response right after release
        use_plus4 = 1'b1; imem_rdata = 32'h0000_0013;
        rst = 1'b1; #1; rst = 1'b0;
        step(); chk("r2_addr", imem_addr, 32'h0); chk("r2_fault", {29'b0, fetch_fault, fault_cause}, 32'd0);
        step(); chk("r2_wait_req", {31'b0, imem_req}, 32'd0);
        rst = 1'b1; #1;
        chk("midwait_count", fetch_count, 32'd0); chk("midwait_pc", pc, 32'h0); chk("midwait_valid", {31'b0, instr_valid}, 32'd0);
        step(); rst = 1'b0; rv_force = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step(); rv_force = 1'b0; imem_rdata = 32'h0000_0013;
        chk("stale_req", {31'b0, imem_req}, 32'd1); chk("stale_addr", imem_addr, 32'h0);
        chk("stale_valid", {31'b0, instr_valid}, 32'd0); chk("stale_instr", instr, 32'h0);
        step(); chk("stale_wait_valid", {31'b0, instr_valid}, 32'd0);
        step(); chk("r2_valid", {31'b0, instr_valid}, 32'd1); chk("r2_instr", instr, 32'h13);
        step(); step(); step();
        step(); chk("be_addr", imem_addr, 32'h8);
        imem_err = 1'b1; imem_rdata = 32'hFFFF_0000;
        step(); step();
        chk("be_fault", {31'b0, fetch_fault}, 32'd1); chk("be_cause", {30'b0, fault_cause}, 32'd1);
        chk("be_instr", instr, 32'h13); chk("be_valid", {31'b0, instr_valid}, 32'd0);
        chk("be_pc", pc, 32'h8);
        for (int i = 0; i < 10; i++) begin step(); chk("be_noreq", {31'b0, imem_req}, 32'd0); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
